// File: rtl/uart_print_pkg.sv
// uart_print_pkg: shared types, constants and the bit-timing helper for the
// UART print stage. Optional feature macro: UART_PRINT_PARITY_EN (8E1 frames).
package uart_print_pkg;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   DATA_BITS       = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_PRINT_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_state_t;

    // Clocks per bit (truncating); returns 0 for an unusable ratio so the
    // caller can reject it at elaboration.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        if (baud <= 0) return 0;
        if ((clk_freq / baud) < 2) return 0;
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_print_fifo.sv
// print_fifo: single-clock byte FIFO between the POC handshake and the UART
// serialiser. Push is ignored when full, pop is ignored when empty.
module print_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wr_data,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; stale entries are never visible because level gates reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_print_tx.sv
// uart_print_tx: buffers bytes from the POC and serialises them as 8N1
// (8E1 when UART_PRINT_PARITY_EN is defined) on uart_tx.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | line idle; pops the FIFO head as soon as one is available
//   ST_START  | start bit (0) for one bit time
//   ST_DATA   | 8 data bits, LSB first, one bit time each
//   ST_PARITY | even parity over the data byte (parity build only)
//   ST_STOP   | stop bit (1); last cycle pops the next byte for a gapless frame
module uart_print_tx
    import uart_print_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    print_data,
    input  logic                          pulse_request,
    output logic                          print_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_print_tx: CLK_FREQ/BAUD must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_print_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    uart_state_t      state;
    uart_state_t      state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic [7:0]       fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_ok;
    logic             pop;
    logic             bit_done;
    logic             tx_next;
    logic             tx_reg;
`ifdef UART_PRINT_PARITY_EN
    logic             parity_bit;
`endif

    assign print_ready = !fifo_full;
    assign push_ok     = pulse_request && print_ready;
    assign bit_done    = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign busy        = (state != ST_IDLE) || !fifo_empty;
    assign uart_tx     = tx_reg;

    print_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_ok),
        .pop     (pop),
        .wr_data (print_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next state, FIFO pop and the line level for the next cycle.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_next    = UART_IDLE_LEVEL;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                tx_next = 1'b0;
                if (bit_done) state_next = ST_DATA;
            end
            ST_DATA: begin
                tx_next = shift_reg[0];
                if (bit_done && (bit_cnt == 3'(DATA_BITS - 1))) begin
`ifdef UART_PRINT_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_PRINT_PARITY_EN
            ST_PARITY: begin
                tx_next = parity_bit;
                if (bit_done) state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                tx_next = UART_IDLE_LEVEL;
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Baud/bit counters, shift register, registered line and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_reg    <= UART_IDLE_LEVEL;
            overflow  <= 1'b0;
`ifdef UART_PRINT_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if ((state == ST_IDLE) || bit_done) baud_cnt <= '0;
            else                                baud_cnt <= baud_cnt + CNT_W'(1);

            if (state != ST_DATA) bit_cnt <= '0;
            else if (bit_done)    bit_cnt <= bit_cnt + 3'd1;

            if (pop)                                shift_reg <= fifo_rd_data;
            else if ((state == ST_DATA) && bit_done) shift_reg <= {1'b0, shift_reg[7:1]};

`ifdef UART_PRINT_PARITY_EN
            if (pop) parity_bit <= ^fifo_rd_data;
`endif
            tx_reg <= tx_next;

            if (pulse_request && !print_ready) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_print_tx.sv
// tb_uart_print_tx: directed bench for uart_print_tx at 16 clocks per bit
// with a 4-entry FIFO. Build with UART_PRINT_PARITY_EN for the 8E1 variant.
`timescale 1ns/1ps
module tb_uart_print_tx;

    localparam int CPB = 16;
`ifdef UART_PRINT_PARITY_EN
    localparam int FB = 11;
    localparam logic [FB-1:0] LINE_55 = 11'b10010101010;
`else
    localparam int FB = 10;
    localparam logic [FB-1:0] LINE_55 = 10'b1010101010;
`endif
    localparam time FRAME_NS = FB * CPB * 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] print_data = 8'h00;
    logic       pulse_request = 1'b0;
    logic       print_ready;
    logic       uart_tx;
    logic       busy;
    logic       overflow;
    logic [2:0] fifo_level;

    int checks = 0;
    int errors = 0;
    int fall_cnt = 0;

    logic [7:0] rx_bytes[$];
    time        rx_start[$];
`ifdef UART_PRINT_PARITY_EN
    logic       rx_par[$];
`endif

    uart_print_tx #(
        .CLK_FREQ   (1600),
        .BAUD       (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .print_data    (print_data),
        .pulse_request (pulse_request),
        .print_ready   (print_ready),
        .uart_tx       (uart_tx),
        .busy          (busy),
        .overflow      (overflow),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    always @(negedge uart_tx) fall_cnt = fall_cnt + 1;

    // Line receiver: samples mid-bit and records byte, start time and parity.
    initial begin : rx_model
        logic [7:0] b;
        logic       p;
        time        t0;
        forever begin
            @(negedge uart_tx);
            t0 = $time;
            repeat (CPB / 2) @(posedge clk);
            #1;
            if (uart_tx === 1'b0 && !rst) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    #1;
                    b[i] = uart_tx;
                end
                p = 1'b0;
`ifdef UART_PRINT_PARITY_EN
                repeat (CPB) @(posedge clk);
                #1;
                p = uart_tx;
`endif
                repeat (CPB) @(posedge clk);
                #1;
                if (uart_tx === 1'b1) begin
                    rx_bytes.push_back(b);
                    rx_start.push_back(t0);
`ifdef UART_PRINT_PARITY_EN
                    rx_par.push_back(p);
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_rx();
        rx_bytes.delete();
        rx_start.delete();
`ifdef UART_PRINT_PARITY_EN
        rx_par.delete();
`endif
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy && n < 5000) begin
            @(posedge clk);
            n++;
        end
        repeat (CPB + 2) @(posedge clk);
        #1;
        ok = !busy;
    endtask

    task automatic wait_frames(input int n, output bit ok);
        int c = 0;
        while (rx_bytes.size() < n && c < (n + 1) * FB * CPB + 100) begin
            @(posedge clk);
            c++;
        end
        ok = (rx_bytes.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
        checks++; if (print_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", print_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_byte();
        logic [FB-1:0] exp_line;
        exp_line = LINE_55;
        clear_rx();
        @(negedge clk);
        print_data = 8'h55;
        pulse_request = 1'b1;
        @(posedge clk);
        #1;
        pulse_request = 1'b0;
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level_after_push: got %0d expected 1", fifo_level); end
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL single_tx_edge0: got %b expected 1", uart_tx); end
        @(posedge clk);
        #1;
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL single_tx_edge1: got %b expected 1", uart_tx); end
        checks++; if (fifo_level !== 3'd0 || busy !== 1'b1) begin errors++; $display("FAIL single_pop: got level %0d busy %b expected 0 1", fifo_level, busy); end
        @(posedge clk);
        #1;
        checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL single_tx_fall: got %b expected 0", uart_tx); end
        for (int i = 0; i < FB; i++) begin
            repeat ((i == 0) ? CPB / 2 : CPB) @(posedge clk);
            #1;
            checks++; if (uart_tx !== exp_line[i]) begin errors++; $display("FAIL single_line_bit%0d: got %b expected %b", i, uart_tx, exp_line[i]); end
        end
        repeat (CPB / 2 - 2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_end: got %b expected 1", busy); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || uart_tx !== 1'b1) begin errors++; $display("FAIL single_idle: got busy %b tx %b expected 0 1", busy, uart_tx); end
        checks++; if (rx_bytes.size() != 1 || rx_bytes[0] !== 8'h55) begin errors++; $display("FAIL single_rx: got %0d frames expected one 0x55", rx_bytes.size()); end
    endtask

    task automatic test_burst();
        bit         ok;
        logic [2:0] peak;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_start_idle: got busy expected idle"); end
        clear_rx();
        peak = 3'd0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            print_data = exp_b[i];
            pulse_request = 1'b1;
            @(negedge clk);
            if (fifo_level > peak) peak = fifo_level;
        end
        pulse_request = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (fifo_level > peak) peak = fifo_level;
        end
        checks++; if (peak !== 3'd2) begin errors++; $display("FAIL burst_peak_level: got %0d expected 2", peak); end
        wait_frames(3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_frames: got %0d frames expected 3", rx_bytes.size()); end
        if (rx_bytes.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (rx_bytes[i] !== exp_b[i]) begin errors++; $display("FAIL burst_byte%0d: got %h expected %h", i, rx_bytes[i], exp_b[i]); end
            end
            for (int i = 1; i < 3; i++) begin
                checks++; if (rx_start[i] - rx_start[i-1] != FRAME_NS) begin errors++; $display("FAIL burst_gap%0d: got %0t expected %0t", i, rx_start[i] - rx_start[i-1], FRAME_NS); end
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_start_idle: got busy expected idle"); end
        clear_rx();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            print_data = 8'h10 + 8'(i);
            pulse_request = 1'b1;
            @(posedge clk);
            #1;
            if (i == 4) begin
                checks++; if (fifo_level !== 3'd4 || print_ready !== 1'b0) begin errors++; $display("FAIL ovf_full: got level %0d ready %b expected 4 0", fifo_level, print_ready); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow); end
            end
            if (i == 5) begin
                checks++; if (overflow !== 1'b1 || fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_set: got ovf %b level %0d expected 1 4", overflow, fifo_level); end
            end
            @(negedge clk);
        end
        pulse_request = 1'b0;
        wait_frames(5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_frames: got %0d frames expected 5", rx_bytes.size()); end
        repeat (FB * CPB + 50) @(posedge clk);
        #1;
        checks++; if (rx_bytes.size() != 5) begin errors++; $display("FAIL ovf_frame_count: got %0d expected 5", rx_bytes.size()); end
        if (rx_bytes.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (rx_bytes[i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL ovf_byte%0d: got %h expected %h", i, rx_bytes[i], 8'h10 + 8'(i)); end
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_push_pop_full();
        bit ok;
        wait_idle(ok);
        apply_reset();
        #1;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ppf_ovf_cleared: got %b expected 0", overflow); end
        clear_rx();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            print_data = 8'h20 + 8'(i);
            pulse_request = 1'b1;
            @(negedge clk);
        end
        pulse_request = 1'b0;
        repeat (FB * CPB - 4) @(posedge clk);
        #1;
        checks++; if (fifo_level !== 3'd4 || print_ready !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL ppf_before: got level %0d ready %b ovf %b expected 4 0 0", fifo_level, print_ready, overflow); end
        @(negedge clk);
        print_data = 8'h25;
        pulse_request = 1'b1;
        @(posedge clk);
        #1;
        pulse_request = 1'b0;
        checks++; if (fifo_level !== 3'd3 || overflow !== 1'b1 || print_ready !== 1'b1) begin errors++; $display("FAIL ppf_after: got level %0d ovf %b ready %b expected 3 1 1", fifo_level, overflow, print_ready); end
        wait_frames(5, ok);
        repeat (FB * CPB + 50) @(posedge clk);
        #1;
        checks++; if (rx_bytes.size() != 5) begin errors++; $display("FAIL ppf_frame_count: got %0d expected 5", rx_bytes.size()); end
        if (rx_bytes.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (rx_bytes[i] !== 8'h20 + 8'(i)) begin errors++; $display("FAIL ppf_byte%0d: got %h expected %h", i, rx_bytes[i], 8'h20 + 8'(i)); end
            end
        end
    endtask

`ifdef UART_PRINT_PARITY_EN
    task automatic test_parity();
        bit ok;
        wait_idle(ok);
        clear_rx();
        @(negedge clk);
        print_data = 8'h07;
        pulse_request = 1'b1;
        @(negedge clk);
        print_data = 8'h03;
        @(negedge clk);
        pulse_request = 1'b0;
        wait_frames(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL par_frames: got %0d frames expected 2", rx_bytes.size()); end
        if (rx_bytes.size() >= 2) begin
            checks++; if (rx_bytes[0] !== 8'h07 || rx_par[0] !== 1'b1) begin errors++; $display("FAIL par_07: got %h/%b expected 07/1", rx_bytes[0], rx_par[0]); end
            checks++; if (rx_bytes[1] !== 8'h03 || rx_par[1] !== 1'b0) begin errors++; $display("FAIL par_03: got %h/%b expected 03/0", rx_bytes[1], rx_par[1]); end
            checks++; if (rx_start[1] - rx_start[0] != FRAME_NS) begin errors++; $display("FAIL par_frame_len: got %0t expected %0t", rx_start[1] - rx_start[0], FRAME_NS); end
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        bit ok;
        int f0;
        wait_idle(ok);
        apply_reset();
        clear_rx();
        @(negedge clk);
        print_data = 8'hA5;
        pulse_request = 1'b1;
        @(negedge clk);
        print_data = 8'h3C;
        @(negedge clk);
        pulse_request = 1'b0;
        repeat (69) @(posedge clk);
        #1;
        checks++; if (uart_tx !== 1'b0 || fifo_level !== 3'd1) begin errors++; $display("FAIL rmf_bit3: got tx %b level %0d expected 0 1", uart_tx, fifo_level); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rmf_async_tx: got %b expected 1", uart_tx); end
        checks++; if (fifo_level !== 3'd0 || overflow !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmf_cleared: got level %0d ovf %b busy %b expected 0 0 0", fifo_level, overflow, busy); end
        @(negedge clk);
        rst = 1'b0;
        f0 = fall_cnt;
        repeat (3 * FB * CPB) @(posedge clk);
        #1;
        checks++; if (fall_cnt != f0 || uart_tx !== 1'b1) begin errors++; $display("FAIL rmf_no_frames: got %0d new falls tx %b expected 0 1", fall_cnt - f0, uart_tx); end
        checks++; if (busy !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL rmf_idle: got busy %b level %0d expected 0 0", busy, fifo_level); end
    endtask

    initial begin : main
        test_reset();
        test_single_byte();
        test_burst();
        test_overflow();
        test_push_pop_full();
`ifdef UART_PRINT_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
